openframe_gpio_ctrl: RTL and testbench

Wishbone-programmable GPIO controller for the openframe user area, parametrised in pad count. It holds a per-pad configuration register that drives every pad-control output (drive mode, enables, threshold, slew, analog, holdover). It also holds output data registers and synchronises pad inputs. Edges or levels on pad inputs raise per-pad, maskable interrupt status bits. It sits between the user-area Wishbone slave port and the openframe GPIO pad bus.

---
 rtl/openframe_gpio_ctrl.sv | 97 +++++++++
 tb/tb_openframe_gpio_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openframe_gpio_ctrl.sv
// openframe_gpio_ctrl: Wishbone GPIO pad controller with per-pad config, synchronised inputs and maskable interrupts
module openframe_gpio_ctrl #(
    parameter int NPADS = 44
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq,
    input  logic [NPADS-1:0] gpio_in,
    output logic [NPADS-1:0] gpio_out,
    output logic [NPADS-1:0] gpio_oeb,
    output logic [NPADS-1:0] gpio_ieb,
    output logic [NPADS-1:0] gpio_dm2,
    output logic [NPADS-1:0] gpio_dm1,
    output logic [NPADS-1:0] gpio_dm0,
    output logic [NPADS-1:0] gpio_ib_mode_sel,
    output logic [NPADS-1:0] gpio_vtrip_sel,
    output logic [NPADS-1:0] gpio_slow_sel,
    output logic [NPADS-1:0] gpio_analog_en,
    output logic [NPADS-1:0] gpio_analog_sel,
    output logic [NPADS-1:0] gpio_analog_pol,
    output logic [NPADS-1:0] gpio_holdover,
    output logic [NPADS-1:0] gpio_inp_dis
);
    logic [15:0]      cfg [NPADS];
    logic [31:0]      acc [NPADS+1];
    logic [NPADS-1:0] out_r, s1, s2, s3, stat, set;
    logic [9:0]       widx;
    logic             req, wr, unused;
    assign widx = wbs_adr_i[11:2];
    assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr = req & wbs_we_i;
    assign unused = ^{wbs_sel_i, wbs_adr_i[31:12], wbs_adr_i[1:0], wbs_dat_i};
    assign irq = |stat;
    assign gpio_out = out_r;
    assign acc[0] = '0;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? acc[NPADS] : '0;
            s1 <= gpio_in;
            s2 <= s1;
            s3 <= s2;
        end
    end
    for (genvar i = 0; i < NPADS; i++) begin : g_pad
        localparam int B = i % 32;
        localparam logic [9:0] CW = 10'(i);
        localparam logic [9:0] OW = 10'(64 + i / 32);
        localparam logic [9:0] IW = 10'(96 + i / 32);
        localparam logic [9:0] SW = 10'(128 + i / 32);
        // irq_mode: 00 rise, 01 fall, 10 either edge, 11 level-high
        assign set[i] = cfg[i][13] & (cfg[i][15] ? (cfg[i][14] ? s2[i] : s2[i] ^ s3[i])
                                                 : (cfg[i][14] ? ~s2[i] & s3[i] : s2[i] & ~s3[i]));
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                cfg[i] <= 16'h0018;
                out_r[i] <= 1'b0;
                stat[i] <= 1'b0;
            end else begin
                if (wr && widx == CW) cfg[i] <= wbs_dat_i[15:0];
                if (wr && widx == OW) out_r[i] <= wbs_dat_i[B];
                stat[i] <= set[i] | (stat[i] & !(wr && widx == SW && wbs_dat_i[B]));
            end
        end
        assign acc[i+1] = acc[i] | (widx == CW ? {16'h0, cfg[i]} : 32'h0)
                        | ({31'h0, widx == OW && out_r[i]} << B)
                        | ({31'h0, widx == IW && s2[i]} << B)
                        | ({31'h0, widx == SW && stat[i]} << B);
        assign gpio_dm0[i] = cfg[i][0];
        assign gpio_dm1[i] = cfg[i][1];
        assign gpio_dm2[i] = cfg[i][2];
        assign gpio_oeb[i] = cfg[i][3];
        assign gpio_ieb[i] = cfg[i][4];
        assign gpio_ib_mode_sel[i] = cfg[i][5];
        assign gpio_vtrip_sel[i] = cfg[i][6];
        assign gpio_slow_sel[i] = cfg[i][7];
        assign gpio_analog_en[i] = cfg[i][8];
        assign gpio_analog_sel[i] = cfg[i][9];
        assign gpio_analog_pol[i] = cfg[i][10];
        assign gpio_holdover[i] = cfg[i][11];
        assign gpio_inp_dis[i] = cfg[i][12];
    end
endmodule

// File: tb/tb_openframe_gpio_ctrl.sv
// tb_openframe_gpio_ctrl: randomized and directed checks of the GPIO controller against a register/history model
module tb_openframe_gpio_ctrl;
    localparam int N = 44;
    localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;
    logic clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
    logic [3:0] sel = 4'hF;
    logic [31:0] adr = 0, wdat = 0, rdat;
    logic ack, irq;
    logic [N-1:0] gin = '0, gout, goeb, gieb, dm2, dm1, dm0, ibm, vtrip, slow, aen, asel, apol, hold, idis;
    logic [N-1:0] pads [13];
    int checks = 0, fails = 0;
    logic [15:0] cfg_m [64];
    logic [63:0] out_m = 0, stat_m = 0, w1c_m = 0;
    logic [63:0] hist [$];

    always #5 clk = ~clk;

    openframe_gpio_ctrl #(.NPADS(N)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .irq(irq), .gpio_in(gin), .gpio_out(gout), .gpio_oeb(goeb), .gpio_ieb(gieb),
        .gpio_dm2(dm2), .gpio_dm1(dm1), .gpio_dm0(dm0), .gpio_ib_mode_sel(ibm),
        .gpio_vtrip_sel(vtrip), .gpio_slow_sel(slow), .gpio_analog_en(aen),
        .gpio_analog_sel(asel), .gpio_analog_pol(apol), .gpio_holdover(hold), .gpio_inp_dis(idis)
    );

    assign pads[0] = dm0;
    assign pads[1] = dm1;
    assign pads[2] = dm2;
    assign pads[3] = goeb;
    assign pads[4] = gieb;
    assign pads[5] = ibm;
    assign pads[6] = vtrip;
    assign pads[7] = slow;
    assign pads[8] = aen;
    assign pads[9] = asel;
    assign pads[10] = apol;
    assign pads[11] = hold;
    assign pads[12] = idis;

    // hist[0] = input sampled at the last edge, hist[1] one edge older (the IN value), hist[2] older still
    always @(posedge clk) begin
        logic [63:0] now_v, old_v, set_v;
        if (rst) begin
            stat_m = 0;
            hist.delete();
            repeat (3) hist.push_back(64'h0);
        end else begin
            now_v = hist[1];
            old_v = hist[2];
            set_v = 0;
            for (int i = 0; i < N; i++)
                if (cfg_m[i][13])
                    case (cfg_m[i][15:14])
                        2'd0: set_v[i] = now_v[i] && !old_v[i];
                        2'd1: set_v[i] = !now_v[i] && old_v[i];
                        2'd2: set_v[i] = now_v[i] != old_v[i];
                        default: set_v[i] = now_v[i];
                    endcase
            stat_m = (stat_m & ~w1c_m) | set_v;
            hist.push_front(64'(gin));
            void'(hist.pop_back());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [9:0] w = a[11:2];
        if (w < N) return {16'h0, cfg_m[w]};
        case (w)
            10'd64: return out_m[31:0];
            10'd65: return out_m[63:32];
            10'd96: return hist[1][31:0];
            10'd97: return hist[1][63:32];
            10'd128: return stat_m[31:0];
            10'd129: return stat_m[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) cfg_m[i] = (i < N) ? 16'h0018 : 16'h0;
        out_m = 0;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, output logic [31:0] r);
        logic [31:0] e;
        logic [9:0] wi;
        int lat;
        @(negedge clk);
        e = model_read(a);
        wi = a[11:2];
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        if (w && wi == 10'd128) w1c_m = {32'h0, d};
        if (w && wi == 10'd129) w1c_m = {d, 32'h0};
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        r = rdat;
        cyc = 0; stb = 0; we = 0; w1c_m = 0;
        checks++;
        if (lat != 1 || ack !== 1'b1) begin
            fails++;
            $display("FAIL bus_ack addr=%h latency=%0d required=1", a, lat);
        end
        if (!w) begin
            checks++;
            if (r !== e) begin
                fails++;
                $display("FAIL read addr=%h got=%h exp=%h", a, r, e);
            end
        end else begin
            if (wi < N) cfg_m[wi] = d[15:0];
            if (wi == 10'd64) out_m[31:0] = d;
            if (wi == 10'd65) out_m[63:32] = d;
            out_m &= MASK;
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || rdat !== 32'h0) begin
            fails++;
            $display("FAIL ack_pulse addr=%h ack=%b dat=%h exp ack=0 dat=0", a, ack, rdat);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, r);
    endtask

    task automatic check_pads();
        logic [N-1:0] e;
        for (int b = 0; b < 13; b++) begin
            for (int i = 0; i < N; i++) e[i] = cfg_m[i][b];
            checks++;
            if (pads[b] !== e) begin
                fails++;
                $display("FAIL pad_field%0d got=%h exp=%h", b, pads[b], e);
            end
        end
        checks++;
        if (gout !== out_m[N-1:0]) begin
            fails++;
            $display("FAIL gpio_out got=%h exp=%h", gout, out_m[N-1:0]);
        end
    endtask

    task automatic check_irq(input string name, input logic e);
        checks++;
        if (irq !== e) begin
            fails++;
            $display("FAIL %s irq=%b exp=%b", name, irq, e);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] e);
        checks++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, e);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        checks++;
        if (goeb !== 44'hFFF_FFFF_FFFF || gieb !== 44'hFFF_FFFF_FFFF || gout !== '0 || ack !== 0 || rdat !== 0) begin
            fails++;
            $display("FAIL reset_outputs oeb=%h ieb=%h out=%h ack=%b dat=%h", goeb, gieb, gout, ack, rdat);
        end
        check_irq("reset_irq", 1'b0);
        rst = 0;
        check_pads();
        for (int i = 0; i < N; i++) begin
            bus(1'b0, 32'(i * 4), 0, r);
            check_val("reset_cfg", r, 32'h18);
        end
    endtask

    task automatic test_config();
        logic [31:0] r;
        wr(32'h14, 32'h0000_1FFF);
        check_val("cfg5_dm", {29'h0, dm2[5], dm1[5], dm0[5]}, 32'h7);
        check_pads();
        bus(1'b0, 32'h14, 0, r);
        check_val("cfg5_readback", r, 32'h1FFF);
    endtask

    task automatic test_out();
        logic [31:0] r;
        wr(32'h104, 32'hFFFF_FFFF);
        check_val("out1_pads", {20'h0, gout[43:32]}, 32'hFFF);
        check_pads();
        bus(1'b0, 32'h104, 0, r);
        check_val("out1_read", r, 32'hFFF);
        bus(1'b0, 32'h0B0, 0, r);
        check_val("cfg44_read", r, 32'h0);
    endtask

    task automatic test_rise();
        logic [31:0] r;
        wr(32'h0, 32'h2018);
        @(negedge clk) gin[0] = 1;
        @(negedge clk) check_irq("rise_k", 1'b0);
        @(negedge clk) check_irq("rise_k1", 1'b0);
        @(negedge clk) check_irq("rise_k2", 1'b1);
        bus(1'b0, 32'h200, 0, r);
        check_val("rise_stat", r, 32'h1);
        wr(32'h200, 32'h1);
        check_irq("rise_cleared", 1'b0);
        gin[0] = 0;
        repeat (4) @(negedge clk);
        check_irq("rise_no_fall", 1'b0);
    endtask

    task automatic test_modes();
        logic [31:0] r;
        wr(32'h4, 32'hA018);
        @(negedge clk) gin[1] = 1;
        repeat (3) @(negedge clk);
        check_irq("both_rise", 1'b1);
        wr(32'h200, 32'h2);
        check_irq("both_clr", 1'b0);
        gin[1] = 0;
        repeat (3) @(negedge clk);
        check_irq("both_fall", 1'b1);
        bus(1'b0, 32'h200, 0, r);
        check_val("both_stat", r, 32'h2);
        wr(32'h200, 32'h2);
        wr(32'h8, 32'hE018);
        @(negedge clk) gin[2] = 1;
        repeat (3) @(negedge clk);
        wr(32'h200, 32'h4);
        bus(1'b0, 32'h200, 0, r);
        check_val("level_held", r, 32'h4);
        gin[2] = 0;
        repeat (3) @(negedge clk);
        wr(32'h200, 32'h4);
        bus(1'b0, 32'h200, 0, r);
        check_val("level_cleared", r, 32'h0);
        check_irq("level_irq", 1'b0);
    endtask

    task automatic test_collision();
        logic [31:0] r;
        @(negedge clk) gin[0] = 1;
        @(negedge clk);
        bus(1'b1, 32'h200, 32'h1, r);
        check_irq("collision_irq", 1'b1);
        bus(1'b0, 32'h200, 0, r);
        check_val("collision_stat", r, 32'h1);
        wr(32'h200, 32'h1);
        gin[0] = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        @(negedge clk);
        e = model_read(32'h14);
        cyc = 1; stb = 1; we = 0; adr = 32'h14;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("b2b_ack", {31'h0, ack}, (c % 2 == 0) ? 32'h1 : 32'h0);
            check_val("b2b_dat", rdat, (c % 2 == 0) ? e : 32'h0);
        end
        cyc = 0; stb = 0;
        @(negedge clk);
    endtask

    task automatic test_random_regs();
        logic [31:0] a, d, r;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: a = 32'($urandom_range(0, 63) * 4);
                1: a = 32'h100;
                2: a = 32'h104;
                3: a = 32'h180 + 32'($urandom_range(0, 1) * 4);
                default: a = $urandom & 32'hFFC;
            endcase
            a |= $urandom & 32'hFFFF_F000;
            d = $urandom;
            wr(a, d);
            check_pads();
            bus(1'b0, a, 0, r);
        end
    endtask

    task automatic test_random_irq();
        logic [31:0] r;
        for (int i = 0; i < N; i++) wr(32'(i * 4), $urandom & 32'hFFFF);
        wr(32'h200, 32'hFFFF_FFFF);
        wr(32'h204, 32'hFFFF_FFFF);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            check_irq("rand_irq", |stat_m);
            gin = gin ^ N'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
        end
        repeat (4) @(negedge clk);
        bus(1'b0, 32'h200, 0, r);
        bus(1'b0, 32'h204, 0, r);
        bus(1'b0, 32'h180, 0, r);
        bus(1'b0, 32'h184, 0, r);
        wr(32'h200, 32'hFFFF_FFFF);
        wr(32'h204, 32'hFFFF_FFFF);
        bus(1'b0, 32'h200, 0, r);
        bus(1'b0, 32'h204, 0, r);
        check_irq("rand_irq_final", |stat_m);
    endtask

    task automatic test_reset_collision();
        logic [31:0] r;
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'hC; wdat = 32'h1FFF; rst = 1;
        @(negedge clk);
        check_val("rst_ack", {31'h0, ack}, 32'h0);
        cyc = 0; stb = 0; we = 0; rst = 0;
        model_reset();
        @(negedge clk);
        check_val("rst_ack_after", {31'h0, ack}, 32'h0);
        bus(1'b0, 32'hC, 0, r);
        check_val("rst_cfg3", r, 32'h18);
        check_pads();
        check_irq("rst_irq", 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_config();
        test_out();
        test_rise();
        test_modes();
        test_collision();
        test_back_to_back();
        test_random_regs();
        test_random_irq();
        test_reset_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
